// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: states, opcodes, ALU codes
// and DataPath bus bit positions.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_T0        = 4'd0,
      ST_T1        = 4'd1,
      ST_T2        = 4'd2,
      ST_T3        = 4'd3,
      ST_T4        = 4'd4,
      ST_T5        = 4'd5,
      ST_T6        = 4'd6,
      ST_T7        = 4'd7,
      ST_HALT      = 4'd8,
      ST_STEP_WAIT = 4'd9
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_OR   = 5'd2;
   localparam logic [4:0] OP_AND  = 5'd3;
   localparam logic [4:0] OP_SHR  = 5'd4;
   localparam logic [4:0] OP_SHL  = 5'd5;
   localparam logic [4:0] OP_ROR  = 5'd6;
   localparam logic [4:0] OP_ROL  = 5'd7;
   localparam logic [4:0] OP_ADDI = 5'd8;
   localparam logic [4:0] OP_ANDI = 5'd9;
   localparam logic [4:0] OP_ORI  = 5'd10;
   localparam logic [4:0] OP_LD   = 5'd16;
   localparam logic [4:0] OP_ST   = 5'd17;
   localparam logic [4:0] OP_NOP  = 5'd27;
   localparam logic [4:0] OP_HALT = 5'd28;

   localparam logic [15:0] ALU_ADD   = 16'h0000;
   localparam logic [15:0] ALU_SUB   = 16'h0001;
   localparam logic [15:0] ALU_OR    = 16'h0002;
   localparam logic [15:0] ALU_AND   = 16'h0003;
   localparam logic [15:0] ALU_SHR   = 16'h0004;
   localparam logic [15:0] ALU_SHL   = 16'h0005;
   localparam logic [15:0] ALU_ROR   = 16'h0006;
   localparam logic [15:0] ALU_ROL   = 16'h0007;
   localparam logic [15:0] ALU_INCPC = 16'h0010;

   localparam int SEL_ZLOW = 19;
   localparam int SEL_PC   = 20;
   localparam int SEL_MDR  = 21;
   localparam int SEL_C    = 23;

   function automatic logic is_rtype(input logic [4:0] op);
      return op <= OP_ROL;
   endfunction

   function automatic logic is_itype(input logic [4:0] op);
      return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
   endfunction

   function automatic logic is_mem(input logic [4:0] op);
      return (op == OP_LD) || (op == OP_ST);
   endfunction

   function automatic logic [15:0] alu_imm(input logic [4:0] op);
      case (op)
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/sel_decode_4to16.sv
// One-hot register select (R0-R15) from a 4-bit IR field, forced to zero when disabled.
module sel_decode_4to16 (
   input  logic [3:0]  i_field,
   input  logic        i_en,
   output logic [15:0] o_sel
);

   always_comb begin
      o_sel = '0;
      if (i_en) o_sel[i_field] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit driving the DataPath control bus.
// Optional single-step gating before every fetch: define CS_SINGLE_STEP_EN.
//
// state      | meaning
// T0         | PC -> MAR, Zlow <= PC + 1
// T1         | memory read of instruction, waits on mem_ready, PC <= Zlow on ready
// T2         | MDR -> IR, decode
// T3..T5     | operand / ALU / writeback (or address generation for LD/ST)
// T6, T7     | LD/ST memory phase, waits on mem_ready
// HALT       | HALT executed, parked until clear
// STEP_WAIT  | single-step idle before next T0 (CS_SINGLE_STEP_EN only)
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int SEL_W  = 32,
   parameter int ALUC_W = 16
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [DATA_W-1:0] ir_data,
   input  logic              mem_ready,
   input  logic              step,
   output logic [SEL_W-1:0]  Rin,
   output logic [SEL_W-1:0]  Rout,
   output logic [ALUC_W-1:0] ALUControl,
   output logic              IRin,
   output logic              MARin,
   output logic              RYin,
   output logic              MDRread,
   output logic              MDRwrite,
   output logic              PCjump,
   output logic              halted,
   output logic              illegal,
   output logic [3:0]        state_dbg
);

`ifdef CS_SINGLE_STEP_EN
   localparam state_t END_ST = ST_STEP_WAIT;
`else
   localparam state_t END_ST = ST_T0;
`endif

   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_ir;

   logic [4:0]        w_op;
   logic [4:0]        w_dec_op;
   logic [3:0]        w_ra;
   logic [3:0]        w_rb;
   logic [3:0]        w_rc;
   logic              w_dec_exec;
   logic              w_dec_known;

   logic [SEL_W-1:0]  w_rin_fix;
   logic [SEL_W-1:0]  w_rout_fix;
   logic              w_rin_en;
   logic              w_rout_en;
   logic [3:0]        w_rout_field;
   logic [15:0]       w_rin_reg;
   logic [15:0]       w_rout_reg;
   logic              w_unused;

   assign w_op     = r_ir[31:27];
   assign w_ra     = r_ir[26:23];
   assign w_rb     = r_ir[22:19];
   assign w_rc     = r_ir[18:15];
   // T2 decides the next state before the IR register holds the new word.
   assign w_dec_op    = ir_data[31:27];
   assign w_dec_exec  = is_rtype(w_dec_op) || is_itype(w_dec_op) || is_mem(w_dec_op);
   assign w_dec_known = w_dec_exec || (w_dec_op == OP_NOP) || (w_dec_op == OP_HALT);

   // Immediate bits only feed the DataPath's Cout path, not this block.
   assign w_unused = ^{r_ir[14:0], step};

   always_ff @(posedge clock) begin
      if (clear) begin
         r_state <= ST_T0;
         r_ir    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_T2) r_ir <= ir_data;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_T0: w_next = ST_T1;
         ST_T1: if (mem_ready) w_next = ST_T2;
         ST_T2: begin
            if (w_dec_exec)                 w_next = ST_T3;
            else if (w_dec_op == OP_HALT)   w_next = ST_HALT;
            else                            w_next = END_ST;
         end
         ST_T3: w_next = ST_T4;
         ST_T4: w_next = ST_T5;
         ST_T5: w_next = is_mem(w_op) ? ST_T6 : END_ST;
         ST_T6: if ((w_op == OP_ST) || mem_ready) w_next = ST_T7;
         ST_T7: if ((w_op == OP_LD) || mem_ready) w_next = END_ST;
         ST_HALT: w_next = ST_HALT;
`ifdef CS_SINGLE_STEP_EN
         ST_STEP_WAIT: if (step) w_next = ST_T0;
`endif
         default: w_next = ST_T0;
      endcase
   end

   always_comb begin
      w_rin_fix    = '0;
      w_rout_fix   = '0;
      w_rin_en     = 1'b0;
      w_rout_en    = 1'b0;
      w_rout_field = w_rb;
      ALUControl   = '0;
      IRin         = 1'b0;
      MARin        = 1'b0;
      RYin         = 1'b0;
      MDRread      = 1'b0;
      MDRwrite     = 1'b0;
      halted       = 1'b0;
      illegal      = 1'b0;
      if (!clear) begin
         case (r_state)
            ST_T0: begin
               w_rout_fix[SEL_PC]  = 1'b1;
               MARin               = 1'b1;
               ALUControl          = ALUC_W'(ALU_INCPC);
               w_rin_fix[SEL_ZLOW] = 1'b1;
            end
            ST_T1: begin
               w_rout_fix[SEL_ZLOW] = 1'b1;
               w_rin_fix[SEL_PC]    = mem_ready;
               w_rin_fix[SEL_MDR]   = 1'b1;
               MDRread              = 1'b1;
            end
            ST_T2: begin
               w_rout_fix[SEL_MDR] = 1'b1;
               IRin                = 1'b1;
               illegal             = !w_dec_known;
            end
            ST_T3: begin
               w_rout_en = 1'b1;
               RYin      = 1'b1;
            end
            ST_T4: begin
               w_rin_fix[SEL_ZLOW] = 1'b1;
               if (is_rtype(w_op)) begin
                  w_rout_en    = 1'b1;
                  w_rout_field = w_rc;
                  ALUControl   = ALUC_W'(w_op);
               end else begin
                  w_rout_fix[SEL_C] = 1'b1;
                  ALUControl        = ALUC_W'(alu_imm(w_op));
               end
            end
            ST_T5: begin
               w_rout_fix[SEL_ZLOW] = 1'b1;
               if (is_mem(w_op)) MARin    = 1'b1;
               else              w_rin_en = 1'b1;
            end
            ST_T6: begin
               w_rin_fix[SEL_MDR] = 1'b1;
               if (w_op == OP_LD) begin
                  MDRread = 1'b1;
               end else begin
                  w_rout_en    = 1'b1;
                  w_rout_field = w_ra;
               end
            end
            ST_T7: begin
               if (w_op == OP_LD) begin
                  w_rout_fix[SEL_MDR] = 1'b1;
                  w_rin_en            = 1'b1;
               end else begin
                  MDRwrite = 1'b1;
               end
            end
            ST_HALT: halted = 1'b1;
            default: ;
         endcase
      end
   end

   sel_decode_4to16 u_rin_dec (
      .i_field (w_ra),
      .i_en    (w_rin_en),
      .o_sel   (w_rin_reg)
   );

   sel_decode_4to16 u_rout_dec (
      .i_field (w_rout_field),
      .i_en    (w_rout_en),
      .o_sel   (w_rout_reg)
   );

   assign Rin       = w_rin_fix  | SEL_W'(w_rin_reg);
   assign Rout      = w_rout_fix | SEL_W'(w_rout_reg);
   assign PCjump    = 1'b0;
   assign state_dbg = clear ? 4'd0 : r_state;

endmodule
